// File: rtl/huffman_decoder.sv
// huffman_decoder
//   Receive side of the Huffman link. Buffers the serial code bitstream, the
//   codeword table ({codeword MSB-first zero-padded, ASCII}) and the per-character
//   code lengths, then walks the bitstream and hands out one decoded byte at a
//   time over a valid/ready handshake.
//
//   Build option HUFF_DEC_ERR_EN: adds err_o. A window that matches no table
//   entry then sets err_o and ends the frame. Without it a miss decodes as 8'h00
//   and decoding carries on.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | nothing received yet
//   RX_BITS | buffering code bits
//   RX_CW   | loading n codeword table entries
//   RX_LN   | loading N per-character code lengths
//   FETCH   | cutting the code window for character i out of the buffer
//   MATCH   | scanning the table, one entry per cycle
//   EMIT    | decoded character on char_o until the sink accepts it
//   DONE    | frame finished, holds until reset

module huffman_decoder #(
  parameter int BIT_WIDTH = 8,
  parameter int MAX_CHAR  = 255,
  parameter int MAX_SYM   = 255,
  parameter int MAX_BITS  = MAX_CHAR * BIT_WIDTH,
  parameter int LEN_W     = $clog2(MAX_SYM) / 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   bit_valid_i,
  input  logic                   bit_i,
  input  logic                   st_cw_i,
  input  logic [BIT_WIDTH-1:0]   num_n_i,
  input  logic [BIT_WIDTH-1:0]   num_N_i,
  input  logic                   cw_valid_i,
  input  logic [2*BIT_WIDTH-1:0] data_cw_i,
  input  logic                   ln_valid_i,
  input  logic [LEN_W-1:0]       data_ln_i,
  output logic                   char_valid_o,
  input  logic                   char_ready_i,
  output logic [BIT_WIDTH-1:0]   char_o,
  output logic                   done_o,
  output logic                   ovf_o
`ifdef HUFF_DEC_ERR_EN
  ,
  output logic                   err_o
`endif
);

  localparam int PTR_W  = $clog2(MAX_BITS + 1);
  localparam int IDX_W  = $clog2(MAX_BITS);
  localparam int POS_W  = PTR_W + 1;
  localparam int CNT_W  = BIT_WIDTH;
  localparam int CNT1_W = CNT_W + 1;
  localparam int SYM_IW = $clog2(MAX_SYM);
  localparam int CHR_IW = $clog2(MAX_CHAR);
  localparam int CLEN_W = $clog2(BIT_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, RX_BITS, RX_CW, RX_LN, FETCH, MATCH, EMIT, DONE
  } state_t;

  state_t state_q, state_d;

  logic [MAX_BITS-1:0]    bits_q;
  logic [2*BIT_WIDTH-1:0] tbl_mem [MAX_SYM];
  logic [LEN_W-1:0]       len_mem [MAX_CHAR];

  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     n_sym_q, n_chr_q;
  logic [CNT_W-1:0]     cw_cnt_q, ln_cnt_q, chr_idx_q, k_q;
  logic [BIT_WIDTH-1:0] win_q, win_d, char_q;
  logic [CLEN_W-1:0]    len_q, len_eff;
  logic [LEN_W-1:0]     len_raw;
  logic [POS_W-1:0]     pos;
  logic                 ovf_q;
`ifdef HUFF_DEC_ERR_EN
  logic                 err_q;
`endif

  logic                   rx_bits_st, wr_full, bit_we;
  logic                   cw_we, ln_we;
  logic                   cw_last, ln_last, chr_last;
  logic [2*BIT_WIDTH-1:0] tbl_rd;
  logic                   hit, miss;

  assign rx_bits_st = (state_q == IDLE) || (state_q == RX_BITS);
  assign wr_full    = (wr_ptr_q == PTR_W'(MAX_BITS));
  assign bit_we     = rx_bits_st && bit_valid_i && !wr_full;
  assign cw_we      = (state_q == RX_CW) && cw_valid_i && (n_sym_q != '0);
  assign ln_we      = (state_q == RX_LN) && ln_valid_i && (n_chr_q != '0);

  assign cw_last  = ({1'b0, cw_cnt_q} + CNT1_W'(1)) == {1'b0, n_sym_q};
  assign ln_last  = ({1'b0, ln_cnt_q} + CNT1_W'(1)) == {1'b0, n_chr_q};
  assign chr_last = ({1'b0, chr_idx_q} + CNT1_W'(1)) == {1'b0, n_chr_q};

  // Table scan: an entry only counts while k is inside the loaded table; running
  // off the end of the table (or an empty table) is a miss.
  assign tbl_rd = tbl_mem[k_q[SYM_IW-1:0]];
  assign hit    = (k_q < n_sym_q) && (tbl_rd[2*BIT_WIDTH-1:BIT_WIDTH] == win_q);
  assign miss   = !hit && (({1'b0, k_q} + CNT1_W'(1)) >= {1'b0, n_sym_q});

  assign char_valid_o = (state_q == EMIT);
  assign char_o       = char_q;
  assign done_o       = (state_q == DONE);
  assign ovf_o        = ovf_q;
`ifdef HUFF_DEC_ERR_EN
  assign err_o        = err_q;
`endif

  // Clamp the code length of the current character to the window width.
  always_comb begin
    len_raw = len_mem[chr_idx_q[CHR_IW-1:0]];
    len_eff = CLEN_W'(BIT_WIDTH);
    if (int'(len_raw) <= BIT_WIDTH) len_eff = CLEN_W'(len_raw);
  end

  // Left-aligned code window; bits past the write pointer were never received and read as 0.
  always_comb begin
    win_d = '0;
    pos   = '0;
    for (int j = 0; j < BIT_WIDTH; j++) begin
      pos = {1'b0, rd_ptr_q} + POS_W'(j);
      if ((j < int'(len_eff)) && (pos < {1'b0, wr_ptr_q}))
        win_d[BIT_WIDTH-1-j] = bits_q[pos[IDX_W-1:0]];
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (st_cw_i)          state_d = RX_CW;
        else if (bit_valid_i) state_d = RX_BITS;
      end
      RX_BITS: begin
        if (st_cw_i) state_d = RX_CW;
      end
      RX_CW: begin
        if ((n_sym_q == '0) || (cw_valid_i && cw_last)) state_d = RX_LN;
      end
      RX_LN: begin
        if (n_chr_q == '0)               state_d = DONE;
        else if (ln_valid_i && ln_last)  state_d = FETCH;
      end
      FETCH: state_d = MATCH;
      MATCH: begin
        if ((len_q == '0) || hit) state_d = EMIT;
`ifdef HUFF_DEC_ERR_EN
        else if (miss)            state_d = DONE;
`else
        else if (miss)            state_d = EMIT;
`endif
      end
      EMIT: begin
        if (char_ready_i) state_d = chr_last ? DONE : FETCH;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Control datapath: pointers, counters, latched frame sizes, window and result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      n_sym_q   <= '0;
      n_chr_q   <= '0;
      cw_cnt_q  <= '0;
      ln_cnt_q  <= '0;
      chr_idx_q <= '0;
      k_q       <= '0;
      win_q     <= '0;
      len_q     <= '0;
      char_q    <= '0;
`ifdef HUFF_DEC_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      if (rx_bits_st && bit_valid_i) begin
        if (wr_full) ovf_q    <= 1'b1;
        else         wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (rx_bits_st && st_cw_i) begin
        n_sym_q <= num_n_i;
        n_chr_q <= num_N_i;
      end
      if (cw_we) cw_cnt_q <= cw_cnt_q + CNT_W'(1);
      if (ln_we) ln_cnt_q <= ln_cnt_q + CNT_W'(1);

      case (state_q)
        FETCH: begin
          win_q <= win_d;
          len_q <= len_eff;
          k_q   <= '0;
        end
        MATCH: begin
          if (len_q == '0) begin
            char_q <= tbl_mem[0][BIT_WIDTH-1:0];
          end else if (hit) begin
            char_q <= tbl_rd[BIT_WIDTH-1:0];
          end else if (miss) begin
`ifdef HUFF_DEC_ERR_EN
            err_q  <= 1'b1;
`else
            char_q <= '0;
`endif
          end else begin
            k_q <= k_q + CNT_W'(1);
          end
        end
        EMIT: begin
          if (char_ready_i) begin
            rd_ptr_q  <= rd_ptr_q + PTR_W'(len_q);
            chr_idx_q <= chr_idx_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Bitstream buffer; contents need no reset since reads are bounded by wr_ptr.
  always_ff @(posedge clk_i) begin
    if (bit_we) bits_q[wr_ptr_q[IDX_W-1:0]] <= bit_i;
  end

  // Codeword table and code-length storage.
  always_ff @(posedge clk_i) begin
    if (cw_we) tbl_mem[cw_cnt_q[SYM_IW-1:0]] <= data_cw_i;
    if (ln_we) len_mem[ln_cnt_q[CHR_IW-1:0]] <= data_ln_i;
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: table of directed frames, hand sequences for
// backpressure / overflow / mid-frame reset, and random frames against a
// character-level reference model.
module tb_huffman_decoder;

  localparam int MAX_BITS = 2040;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        bit_valid_i = 1'b0, bit_i = 1'b0, st_cw_i = 1'b0;
  logic [7:0]  num_n_i = '0, num_N_i = '0;
  logic        cw_valid_i = 1'b0;
  logic [15:0] data_cw_i = '0;
  logic        ln_valid_i = 1'b0;
  logic [3:0]  data_ln_i = '0;
  logic        char_valid_o, char_ready_i = 1'b1;
  logic [7:0]  char_o;
  logic        done_o, ovf_o;
`ifdef HUFF_DEC_ERR_EN
  logic        err_o;
`endif

  huffman_decoder dut (
`ifdef HUFF_DEC_ERR_EN
    .err_o(err_o),
`endif
    .clk_i(clk_i), .rst_i(rst_i),
    .bit_valid_i(bit_valid_i), .bit_i(bit_i),
    .st_cw_i(st_cw_i), .num_n_i(num_n_i), .num_N_i(num_N_i),
    .cw_valid_i(cw_valid_i), .data_cw_i(data_cw_i),
    .ln_valid_i(ln_valid_i), .data_ln_i(data_ln_i),
    .char_valid_o(char_valid_o), .char_ready_i(char_ready_i),
    .char_o(char_o), .done_o(done_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Frame description shared by loader and model.
  bit          g_bits[$];
  logic [15:0] g_tbl[$];
  logic [3:0]  g_lens[$];
  logic [7:0]  exp_q[$];
  bit          exp_err;
  logic [7:0]  got[$];

  // Output monitor: collects accepted chars and flags a char that changes or vanishes while stalled.
  int         stab_bad = 0;
  bit         pend = 0;
  logic [7:0] pend_chr = '0;
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) pend = 0;
      else begin
        if (pend && (!char_valid_o || char_o !== pend_chr)) stab_bad++;
        if (char_valid_o && char_ready_i) begin
          got.push_back(char_o);
          pend = 0;
        end else if (char_valid_o) begin
          pend = 1;
          pend_chr = char_o;
        end else pend = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    bit_valid_i = 0; st_cw_i = 0; cw_valid_i = 0; ln_valid_i = 0;
    repeat (2) tick();
    got.delete();
    rst_i = 1'b0;
  endtask

  task automatic send_tables();
    tick();
    bit_valid_i = 0;
    st_cw_i = 1;
    num_n_i = 8'(g_tbl.size());
    num_N_i = 8'(g_lens.size());
    tick();
    st_cw_i = 0;
    foreach (g_tbl[k]) begin
      cw_valid_i = 1;
      data_cw_i = g_tbl[k];
      tick();
    end
    cw_valid_i = 0;
    tick();
    foreach (g_lens[i]) begin
      ln_valid_i = 1;
      data_ln_i = g_lens[i];
      tick();
    end
    ln_valid_i = 0;
  endtask

  task automatic load_frame();
    foreach (g_bits[j]) begin
      tick();
      bit_valid_i = 1;
      bit_i = g_bits[j];
    end
    send_tables();
  endtask

  task automatic collect(input int budget, input bit rnd);
    for (int c = 0; c < budget && !done_o; c++) begin
      tick();
      char_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("done_reached", done_o, 1);
    char_ready_i = 1'b1;
  endtask

  // Reference: decode the text from the frame description character by character.
  task automatic run_model();
    int ptr, L, n;
    logic [7:0] w, c;
    bit found;
    exp_q.delete();
    exp_err = 0;
    ptr = 0;
    n = g_tbl.size();
    foreach (g_lens[i]) begin
      L = (g_lens[i] > 8) ? 8 : int'(g_lens[i]);
      if (L == 0) c = g_tbl[0][7:0];
      else begin
        w = '0;
        for (int j = 0; j < L; j++)
          if (ptr + j < g_bits.size() && ptr + j < MAX_BITS) w[7-j] = g_bits[ptr+j];
        found = 0;
        c = 8'h00;
        for (int k = 0; k < n; k++)
          if (!found && g_tbl[k][15:8] == w) begin
            found = 1;
            c = g_tbl[k][7:0];
          end
`ifdef HUFF_DEC_ERR_EN
        if (!found) begin
          exp_err = 1;
          break;
        end
`endif
      end
      exp_q.push_back(c);
      ptr += L;
    end
  endtask

  task automatic compare_frame(input string name);
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_char%0d", name, i), got[i], exp_q[i]);
`ifdef HUFF_DEC_ERR_EN
    chk({name, "_err"}, err_o, exp_err);
`endif
  endtask

  typedef struct packed {
    logic [7:0]       nbits;
    logic [63:0]      bits;
    logic [7:0]       n;
    logic [3:0][15:0] tbl;
    logic [7:0]       nn;
    logic [7:0][3:0]  lens;
    logic [7:0]       ecnt;
    logic [7:0][7:0]  echr;
    logic             eerr;
  } vec_t;

  vec_t vecs[3];

  task automatic vec_to_globals(input int v);
    g_bits.delete(); g_tbl.delete(); g_lens.delete(); exp_q.delete();
    for (int j = 0; j < int'(vecs[v].nbits); j++) g_bits.push_back(vecs[v].bits[j]);
    for (int k = 0; k < int'(vecs[v].n); k++)     g_tbl.push_back(vecs[v].tbl[k]);
    for (int i = 0; i < int'(vecs[v].nn); i++)    g_lens.push_back(vecs[v].lens[i]);
    for (int i = 0; i < int'(vecs[v].ecnt); i++)  exp_q.push_back(vecs[v].echr[i]);
    exp_err = vecs[v].eerr;
  endtask

  initial begin
    int n, nn, s, L;
    int clen[8];
    logic [7:0] cw;

    // Frame 1: bits 0,1,0,0,1,1 ; table {00,41},{80,42},{C0,43}; lens 1,2,1,2
    vecs[0] = '0;
    vecs[0].nbits = 6; vecs[0].bits = 64'b110010;
    vecs[0].n = 3;
    vecs[0].tbl[0] = 16'h0041; vecs[0].tbl[1] = 16'h8042; vecs[0].tbl[2] = 16'hC043;
    vecs[0].nn = 4;
    vecs[0].lens[0] = 1; vecs[0].lens[1] = 2; vecs[0].lens[2] = 1; vecs[0].lens[3] = 2;
    vecs[0].ecnt = 4;
    vecs[0].echr[0] = 8'h41; vecs[0].echr[1] = 8'h42; vecs[0].echr[2] = 8'h41; vecs[0].echr[3] = 8'h43;
    // Single-symbol frame: zero-length codes, no bits.
    vecs[1] = '0;
    vecs[1].n = 1; vecs[1].tbl[0] = 16'h005A;
    vecs[1].nn = 3;
    vecs[1].ecnt = 3;
    vecs[1].echr[0] = 8'h5A; vecs[1].echr[1] = 8'h5A; vecs[1].echr[2] = 8'h5A;
    // Window E0 (bits 1,1,1) not in table, then bit 0 (len 1).
    vecs[2] = '0;
    vecs[2].nbits = 4; vecs[2].bits = 64'b0111;
    vecs[2].n = 3;
    vecs[2].tbl[0] = 16'h0041; vecs[2].tbl[1] = 16'h8042; vecs[2].tbl[2] = 16'hC043;
    vecs[2].nn = 2; vecs[2].lens[0] = 3; vecs[2].lens[1] = 1;
`ifdef HUFF_DEC_ERR_EN
    vecs[2].ecnt = 0; vecs[2].eerr = 1;
`else
    vecs[2].ecnt = 2; vecs[2].echr[0] = 8'h00; vecs[2].echr[1] = 8'h41;
`endif

    rst_i = 1'b1;
    #2;
    chk("rst_valid", char_valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ovf", ovf_o, 0);
`ifdef HUFF_DEC_ERR_EN
    chk("rst_err", err_o, 0);
`endif
    do_reset();

    // Directed frames.
    for (int v = 0; v < 3; v++) begin
      do_reset();
      vec_to_globals(v);
      char_ready_i = 1'b1;
      load_frame();
      collect(200, 0);
      compare_frame($sformatf("vec%0d", v));
    end

    // Backpressure on the second character.
    do_reset();
    vec_to_globals(0);
    char_ready_i = 1'b1;
    load_frame();
    for (int c = 0; c < 50 && got.size() < 1; c++) tick();
    chk("bp_first_taken", got.size(), 1);
    char_ready_i = 1'b0;
    for (int c = 0; c < 50 && !char_valid_o; c++) tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", char_valid_o, 1);
      chk("bp_hold_char", char_o, 8'h42);
      tick();
    end
    char_ready_i = 1'b1;
    collect(200, 0);
    compare_frame("bp");

    // Overflow: MAX_BITS+3 bits, each byte one of 00/80/C0, last three bits 1.
    do_reset();
    g_bits.delete(); g_lens.delete();
    g_tbl = '{16'h0041, 16'h8042, 16'hC043};
    for (int i = 0; i < MAX_BITS / 8; i++) begin
      s = $urandom_range(0, 2);
      cw = g_tbl[s][15:8];
      for (int j = 0; j < 8; j++) g_bits.push_back(cw[7-j]);
      g_lens.push_back(4'd8);
    end
    repeat (3) g_bits.push_back(1'b1);
    run_model();
    foreach (g_bits[j]) begin
      tick();
      if (j == MAX_BITS)     chk("ovf_at_max", ovf_o, 0);
      if (j == MAX_BITS + 1) chk("ovf_after_max_plus1", ovf_o, 1);
      bit_valid_i = 1;
      bit_i = g_bits[j];
    end
    send_tables();
    collect(5000, 0);
    compare_frame("ovf_frame");
    chk("ovf_sticky", ovf_o, 1);

    // Reset while a character is being presented, with ovf set.
    do_reset();
    vec_to_globals(0);
    while (g_bits.size() < MAX_BITS + 1) g_bits.push_back(1'b0);
    char_ready_i = 1'b0;
    load_frame();
    for (int c = 0; c < 50 && !char_valid_o; c++) tick();
    chk("mid_valid_before", char_valid_o, 1);
    chk("mid_ovf_before", ovf_o, 1);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", char_valid_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_ovf", ovf_o, 0);
    chk("mid_rst_nochar", got.size(), 0);
    do_reset();
    vec_to_globals(0);
    char_ready_i = 1'b1;
    load_frame();
    collect(200, 0);
    compare_frame("rerun");

    // Random frames with random backpressure.
    for (int it = 0; it < 30; it++) begin
      do_reset();
      g_bits.delete(); g_tbl.delete(); g_lens.delete();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        clen[k] = $urandom_range(1, 4);
        cw = 8'($urandom_range(0, (1 << clen[k]) - 1)) << (8 - clen[k]);
        g_tbl.push_back({cw, 8'($urandom)});
      end
      nn = $urandom_range(1, 12);
      for (int i = 0; i < nn; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          s = $urandom_range(0, n - 1);
          L = clen[s];
          for (int j = 0; j < L; j++) g_bits.push_back(g_tbl[s][15-j]);
        end else begin
          L = $urandom_range(0, 8);
          for (int j = 0; j < L; j++) g_bits.push_back(1'($urandom));
        end
        g_lens.push_back(4'(L));
      end
      if ($urandom_range(0, 3) == 0)
        for (int d = 0; d < 5 && g_bits.size() > 0; d++) void'(g_bits.pop_back());
      run_model();
      char_ready_i = 1'b1;
      load_frame();
      collect(2000, 1);
      compare_frame($sformatf("rnd%0d", it));
    end

    chk("stall_stability", stab_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
